// File: rtl/death_seq.sv
// Death / respawn sequencer: detects Pac-Man vs ghost collisions, runs the death
// animation, handshakes with the lives register and manages grace and game-over.
module death_seq #(
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned GRACE_FRAMES = 30,
    parameter int unsigned HIT_DIST     = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_tick,
    input  logic            start,
    input  logic [9:0]      pac_x,
    input  logic [9:0]      pac_y,
    input  logic [3:0][9:0] ghost_x,
    input  logic [3:0][9:0] ghost_y,
    input  logic [3:0]      frightened,
    input  logic            Reset_game,
    output logic            Restart,
    output logic            respawn,
    output logic            freeze,
    output logic            death_anim,
    output logic [5:0]      anim_frame,
    output logic            game_over,
    output logic [3:0]      ghost_eaten
);

    localparam int unsigned GraceW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

    typedef enum logic [2:0] {
        StPlay, StDying, StRestart, StWaitAck, StGrace, StGameOver
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        anim_q, anim_d;
    logic [GraceW-1:0] grace_q, grace_d;
    logic              wait_q, wait_d;
    logic              ack_q, ack_d;
    logic [3:0]        eat_q;

    logic              restart_d, respawn_d, freeze_d, death_anim_d, game_over_d;
    logic [3:0]        eaten_d;
    logic [3:0]        overlap, eat;
    logic              lethal;

    // 11-bit signed difference so coordinates near 0 and 1023 never wrap into overlap
    function automatic logic near(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[10]) d = -d;
        return d < 11'(HIT_DIST);
    endfunction

    always_comb begin
        overlap = '0;
        for (int i = 0; i < 4; i++) begin
            overlap[i] = near(pac_x, ghost_x[i]) && near(pac_y, ghost_y[i]);
        end
        eat    = overlap & frightened;
        lethal = |(overlap & ~frightened);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StPlay;
            anim_q      <= '0;
            grace_q     <= '0;
            wait_q      <= 1'b0;
            ack_q       <= 1'b0;
            eat_q       <= '0;
            Restart     <= 1'b0;
            respawn     <= 1'b0;
            freeze      <= 1'b0;
            death_anim  <= 1'b0;
            game_over   <= 1'b0;
            ghost_eaten <= '0;
        end else begin
            state_q     <= state_d;
            anim_q      <= anim_d;
            grace_q     <= grace_d;
            wait_q      <= wait_d;
            ack_q       <= ack_d;
            eat_q       <= eat;
            Restart     <= restart_d;
            respawn     <= respawn_d;
            freeze      <= freeze_d;
            death_anim  <= death_anim_d;
            game_over   <= game_over_d;
            ghost_eaten <= eaten_d;
        end
    end

    assign anim_frame = anim_q;

    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        grace_d = grace_q;
        wait_d  = wait_q;
        ack_d   = ack_q;
        unique case (state_q)
            StPlay: begin
                if (lethal) begin
                    state_d = StDying;
                    anim_d  = '0;
                end
            end
            StDying: begin
                if (frame_tick) begin
                    if (anim_q == 6'(DEATH_FRAMES - 1)) begin
                        state_d = StRestart;
                        anim_d  = '0;
                    end else begin
                        anim_d = anim_q + 6'd1;
                    end
                end
            end
            StRestart: begin
                state_d = StWaitAck;
                wait_d  = 1'b0;
                ack_d   = 1'b0;
            end
            // Reset_game may arrive in either WAIT_ACK cycle, so it is made sticky
            StWaitAck: begin
                wait_d = 1'b1;
                ack_d  = ack_q | Reset_game;
                if (wait_q) begin
                    state_d = (ack_q || Reset_game) ? StGameOver : StGrace;
                    grace_d = '0;
                end
            end
            StGrace: begin
                if (frame_tick) begin
                    if (grace_q == GraceW'(GRACE_FRAMES - 1)) begin
                        state_d = StPlay;
                        grace_d = '0;
                    end else begin
                        grace_d = grace_q + GraceW'(1);
                    end
                end
            end
            StGameOver: begin
                if (start) begin
                    state_d = StGrace;
                    grace_d = '0;
                end
            end
            default: state_d = StPlay;
        endcase
    end

    always_comb begin
        freeze_d     = (state_d == StDying) || (state_d == StRestart) ||
                       (state_d == StWaitAck) || (state_d == StGameOver);
        death_anim_d = (state_d == StDying);
        game_over_d  = (state_d == StGameOver);
        restart_d    = (state_d == StRestart);
        respawn_d    = (state_d == StGrace) && (state_q != StGrace);
        eaten_d      = '0;
        // A lethal hit in PLAY wins over any simultaneous eat
        if ((state_q == StPlay && !lethal) || state_q == StGrace) begin
            eaten_d = eat & ~eat_q;
        end
    end

endmodule

// File: tb/tb_death_seq.sv
// Directed bench for death_seq: death/respawn timing, grace immunity, game over,
// ghost eating, asynchronous reset and coordinate boundary cases.
module tb_death_seq;

    logic            Clk, Reset, frame_tick, start, Reset_game;
    logic [9:0]      pac_x, pac_y;
    logic [3:0][9:0] ghost_x, ghost_y;
    logic [3:0]      frightened;
    logic            Restart, respawn, freeze, death_anim, game_over;
    logic [5:0]      anim_frame;
    logic [3:0]      ghost_eaten;

    int n_checks = 0;
    int n_errors = 0;

    death_seq dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .ghost_x    (ghost_x),
        .ghost_y    (ghost_y),
        .frightened (frightened),
        .Reset_game (Reset_game),
        .Restart    (Restart),
        .respawn    (respawn),
        .freeze     (freeze),
        .death_anim (death_anim),
        .anim_frame (anim_frame),
        .game_over  (game_over),
        .ghost_eaten(ghost_eaten)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic place(input int i, input logic [9:0] x, input logic [9:0] y);
        ghost_x[i] = x;
        ghost_y[i] = y;
    endtask

    task automatic ghosts_away();
        for (int i = 0; i < 4; i++) place(i, 10'd500, 10'd500);
        frightened = 4'b0000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {Restart, respawn, freeze, death_anim, game_over}, 0);
        check({tag, "_anim"}, anim_frame, 0);
        check({tag, "_eaten"}, ghost_eaten, 0);
    endtask

    int cnt, cnt2;

    initial begin
        Reset = 1'b0; frame_tick = 1'b0; start = 1'b0; Reset_game = 1'b0;
        pac_x = 10'd100; pac_y = 10'd100;
        ghosts_away();

        #12;
        check_all_zero("reset");
        #10 Reset = 1'b1;
        tick(); tick();
        check("play_freeze", freeze, 0);

        // Coordinate boundary: 1015 vs 0 must not wrap into overlap
        frightened = 4'b0001;
        pac_x = 10'd0;
        place(0, 10'd1015, 10'd100);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ghost_eaten != 0) cnt++;
        end
        check("no_wrap_overlap", cnt, 0);
        pac_x = 10'd1000;
        place(0, 10'd1007, 10'd100);
        tick();
        check("edge_overlap_eat", ghost_eaten, 4'b0001);
        tick();
        check("edge_eat_once", ghost_eaten, 0);
        ghosts_away();
        pac_x = 10'd100;
        tick();

        // Frightened ghost 1 held for 10 cycles -> one pulse
        frightened = 4'b0010;
        place(1, 10'd103, 10'd95);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ghost_eaten != 0) cnt++;
            if (ghost_eaten == 4'b0010) cnt2++;
        end
        check("eat_pulse_count", cnt, 1);
        check("eat_pulse_value", cnt2, 1);
        check("eat_no_freeze", freeze, 0);
        ghosts_away();
        tick();

        // start outside GAME_OVER is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("start_ignored", {respawn, game_over, freeze}, 0);

        // Lethal ghost 2 on Pac-Man
        place(2, 10'd100, 10'd100);
        tick();
        check("dying_flags", {freeze, death_anim}, 2'b11);
        check("dying_anim0", anim_frame, 0);
        for (int i = 0; i < 59; i++) frame();
        check("anim_59", anim_frame, 59);
        check("still_dying", death_anim, 1);
        frame();
        check("restart_pulse", Restart, 1);
        check("restart_flags", {death_anim, freeze}, 2'b01);
        tick();
        check("wait1", {Restart, respawn}, 0);
        tick();
        check("wait2", {Restart, respawn}, 0);
        tick();
        check("respawn_pulse", respawn, 1);
        check("grace_unfreeze", freeze, 0);
        tick();
        check("respawn_once", respawn, 0);

        // Still overlapping ghost 2: immune for the whole grace period
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            frame();
            if (freeze || death_anim || Restart) cnt++;
        end
        check("grace_immune", cnt, 0);
        tick();
        check("play_dies", {freeze, death_anim}, 2'b11);

        // Asynchronous reset in mid-animation
        ghosts_away();
        for (int i = 0; i < 25; i++) frame();
        check("anim_25", anim_frame, 25);
        Reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        #10 Reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            frame();
            if (Restart || freeze || death_anim) cnt++;
        end
        check("post_reset_play", cnt, 0);

        // Death ending in game over
        place(2, 10'd104, 10'd96);
        tick();
        ghosts_away();
        check("dying2", death_anim, 1);
        for (int i = 0; i < 60; i++) frame();
        check("restart2", Restart, 1);
        tick();
        Reset_game = 1'b1;
        tick();
        Reset_game = 1'b0;
        check("ack_wait", {game_over, respawn}, 0);
        tick();
        check("game_over", {game_over, freeze, respawn}, 3'b110);
        for (int i = 0; i < 5; i++) frame();
        check("game_over_hold", {game_over, freeze}, 2'b11);
        start = 1'b1; tick(); start = 1'b0;
        check("go_respawn", respawn, 1);
        check("go_cleared", {game_over, freeze}, 0);
        for (int i = 0; i < 30; i++) frame();
        tick();

        // Lethal ghost 0 and frightened ghost 3 in the same cycle
        frightened = 4'b1000;
        place(0, 10'd100, 10'd100);
        place(3, 10'd101, 10'd99);
        tick();
        check("prio_dying", death_anim, 1);
        check("prio_no_eat", ghost_eaten, 0);
        tick();
        check("prio_no_eat2", ghost_eaten, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/death_seq.md
DEATH_SEQ -- requirements
Module: death_seq

Interface
REQ-001 SHALL have parameter DEATH_FRAMES, default 60: frame ticks spent in the death animation.
REQ-002 SHALL have parameter GRACE_FRAMES, default 30: frame ticks of collision immunity after respawn.
REQ-003 SHALL have parameter HIT_DIST, default 8: a per-axis pixel distance strictly below this counts as overlap.
REQ-004 SHALL have port Clk  input  1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_tick  input  1: one-Clk strobe per video frame.
REQ-007 SHALL have port start  input  1: one-Clk strobe from the start button, already debounced.
REQ-008 SHALL have port pac_x, pac_y  input  10 each: Pac-Man position.
REQ-009 SHALL have port ghost_x, ghost_y  input  4x10 each: positions of ghosts 0..3.
REQ-010 SHALL have port frightened  input  4: per-ghost frightened flag.
REQ-011 SHALL have port Reset_game  input  1: lives-exhausted flag from the lives register; valid exactly 1 Clk after the cycle in which Restart is high.
REQ-012 SHALL have port Restart  output  1: one-Clk life-lost pulse to the lives register.
REQ-013 SHALL have port respawn  output  1: one-Clk pulse telling sprites to return to their home tiles.
REQ-014 SHALL have port freeze  output  1: halts movement logic while high.
REQ-015 SHALL have port death_anim  output  1: high during the death animation.
REQ-016 SHALL have port anim_frame  output  6: death animation frame index.
REQ-017 SHALL have port game_over  output  1: high in GAME_OVER.
REQ-018 SHALL have port ghost_eaten  output  4: one-Clk pulse per ghost eaten.

Function
REQ-019 SHALL implement states PLAY, DYING, RESTART, WAIT_ACK, GRACE and GAME_OVER; all outputs SHALL be registered.
REQ-020 SHALL define overlap[i] as abs(pac_x-ghost_x[i])<HIT_DIST AND abs(pac_y-ghost_y[i])<HIT_DIST, computed on unsigned 10-bit values with an 11-bit difference; no wrap-around.
REQ-021 SHALL treat a lethal hit as overlap[i] with frightened[i]=0 for any i, and SHALL evaluate it only in PLAY.
REQ-022 SHALL, on a lethal hit in PLAY, enter DYING on the next edge with freeze=1, death_anim=1 and anim_frame=0.
REQ-023 SHALL, in DYING, increment anim_frame on each frame_tick; on the frame_tick with anim_frame==DEATH_FRAMES-1 it SHALL go to RESTART.
REQ-024 SHALL hold Restart=1 for exactly the one Clk spent in RESTART, then enter WAIT_ACK; death_anim SHALL be 0 from RESTART onward.
REQ-025 SHALL remain in WAIT_ACK for 2 Clk; if Reset_game=1 in either cycle, go to GAME_OVER, otherwise go to GRACE, pulsing respawn for 1 Clk on entry and setting freeze=0.
REQ-026 SHALL ignore lethal hits in GRACE; after GRACE_FRAMES frame_ticks it SHALL go to PLAY.
REQ-027 SHALL, in GAME_OVER, hold freeze=1 and game_over=1; on start it SHALL pulse respawn and go to GRACE with game_over=0.
REQ-028 SHALL, in PLAY or GRACE, pulse ghost_eaten[i] for 1 Clk on the rising edge of (overlap[i] AND frightened[i]); a continuous overlap yields exactly one pulse.
REQ-029 SHALL give a lethal hit priority: if a lethal and an eating overlap occur in the same cycle, the block enters DYING and ghost_eaten stays 0.
REQ-030 SHALL never assert Restart again before WAIT_ACK completes; start and frame_tick SHALL be ignored in RESTART and WAIT_ACK.
REQ-031 SHALL ignore start outside GAME_OVER.

Reset
REQ-032 SHALL, while Reset=0, immediately force state PLAY, anim_frame=0, all counters and overlap history to 0, and all outputs to 0, including during DYING or WAIT_ACK.
REQ-033 SHALL resume normal operation on the first rising Clk edge after Reset returns to 1.

Verification
REQ-034 Ghost 2 at Pac-Man position, frightened=0 -> DYING next Clk; after 60 frame_ticks, a single Restart pulse; Reset_game=0 -> respawn 3 Clk later, then GRACE.
REQ-035 Lethal overlap held through all 30 GRACE frame_ticks -> no DYING; the still-held overlap triggers DYING on the first PLAY cycle.
REQ-036 Reset_game=1 one Clk after Restart -> GAME_OVER with game_over=1 and freeze=1; start -> respawn pulse, GRACE, game_over=0.
REQ-037 Frightened ghost 1 overlapping for 10 Clk -> exactly one ghost_eaten=4'b0010 pulse; lethal ghost 0 and frightened ghost 3 overlapping in the same cycle -> DYING, ghost_eaten=0.
REQ-038 Reset low at anim_frame=25 in DYING -> all outputs 0 immediately; state PLAY and no Restart pulse after release.
REQ-039 pac_x=0 with ghost_x=1015, then pac_x=1000 with ghost_x=1007 -> no overlap in the first case, overlap in the second.
